// File: rtl/video_timing_gen_pkg.sv
// Shared raster timing definitions for the ULX3S top levels and pdp1_vga_crt.
// Holds the default 1024x768 timing, the offset/total formulas and the bus
// type carried through the sync delay line.
package video_timing_gen_pkg;

  localparam int DEF_CNT_W      = 11;
  localparam int DEF_FCNT_W     = 16;
  localparam int DEF_PIPE_DELAY = 2;

  localparam int DEF_H_VISIBLE = 1024;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 176;

  localparam int DEF_V_VISIBLE = 768;
  localparam int DEF_V_FP      = 3;
  localparam int DEF_V_SYNC    = 6;
  localparam int DEF_V_BP      = 13;

  // Blanking precedes the visible area, so the offset to the first visible
  // pixel/line is the whole blanking interval.
  function automatic int timing_ofs(input int fp, input int sync, input int bp);
    return fp + sync + bp;
  endfunction

  function automatic int timing_total(input int visible, input int fp,
                                      input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic blank;
  } sync_bus_t;

endpackage

// File: rtl/video_timing_gen_sync_delay_line.sv
// sync_delay_line: WIDTH x DEPTH shift register with asynchronous active-high
// reset of every stage to RESET_VAL. DEPTH = 0 is a combinational pass-through.
// Ports:
//   i_clk  clock
//   i_rst  asynchronous active-high reset
//   i_d    WIDTH-bit input
//   o_q    i_d delayed by DEPTH cycles
module sync_delay_line #(
  parameter int unsigned          WIDTH     = 4,
  parameter int unsigned          DEPTH     = 2,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = i_clk ^ i_rst;
    assign o_q = i_d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else begin
        stage[0] <= i_d;
        for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign o_q = stage[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator.
// Line/frame order is front porch, sync, back porch, visible area.
// Ports:
//   i_clk, i_rst          pixel clock, asynchronous active-high reset
//   i_enable              1 = counters advance, 0 = hold
//   i_resync              synchronous restart at (0,0), counts as a frame wrap
//   o_h_counter/o_v_counter  raw counters
//   o_x/o_y               visible coordinates, 0 outside the active area
//   o_active              visible-area flag aligned with the counters
//   o_line_tick/o_frame_tick  one-cycle wrap strobes
//   o_frame_count         frames since reset
//   o_hsync/o_vsync/o_de/o_blank  sync decode delayed by PIPE_DELAY cycles
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int PIPE_DELAY = DEF_PIPE_DELAY,
  parameter int FCNT_W     = DEF_FCNT_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_resync,
  output logic [CNT_W-1:0]  o_h_counter,
  output logic [CNT_W-1:0]  o_v_counter,
  output logic [CNT_W-1:0]  o_x,
  output logic [CNT_W-1:0]  o_y,
  output logic              o_active,
  output logic              o_line_tick,
  output logic              o_frame_tick,
  output logic [FCNT_W-1:0] o_frame_count,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_de,
  output logic              o_blank
);

  localparam int H_OFS   = timing_ofs(H_FP, H_SYNC, H_BP);
  localparam int V_OFS   = timing_ofs(V_FP, V_SYNC, V_BP);
  localparam int H_TOTAL = timing_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  if (CNT_W <= 0 || FCNT_W <= 0 || H_VISIBLE <= 0 || H_SYNC <= 0 ||
      V_VISIBLE <= 0 || V_SYNC <= 0 || PIPE_DELAY < 0) begin : g_bad_width
    $error("video_timing_gen: width parameters must be positive");
  end
  if (((longint'(H_TOTAL) >> CNT_W) != 0) ||
      ((longint'(V_TOTAL) >> CNT_W) != 0)) begin : g_bad_total
    $error("video_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_OFS_C  = CNT_W'(H_OFS);
  localparam logic [CNT_W-1:0] V_OFS_C  = CNT_W'(V_OFS);
  localparam logic [CNT_W-1:0] H_SYN_LO = CNT_W'(H_FP);
  localparam logic [CNT_W-1:0] H_SYN_HI = CNT_W'(H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYN_LO = CNT_W'(V_FP);
  localparam logic [CNT_W-1:0] V_SYN_HI = CNT_W'(V_FP + V_SYNC);

  localparam sync_bus_t RAW_IDLE = '{hsync: ~HS_POL, vsync: ~VS_POL,
                                     de: 1'b0, blank: 1'b1};

  logic [CNT_W-1:0] h_n, v_n, x_n, y_n;
  logic             act_n, line_n, frame_n;
  sync_bus_t        raw_n, raw_q;
  logic [3:0]       raw_bits, del_bits;

  // Next-state counters and strobes. Resync behaves like a forced frame wrap,
  // so a resync on the natural wrap cycle still yields one tick.
  always_comb begin
    h_n     = o_h_counter;
    v_n     = o_v_counter;
    line_n  = 1'b0;
    frame_n = 1'b0;
    if (i_resync) begin
      h_n     = '0;
      v_n     = '0;
      line_n  = 1'b1;
      frame_n = 1'b1;
    end else if (i_enable) begin
      if (o_h_counter == H_LAST) begin
        h_n    = '0;
        line_n = 1'b1;
        if (o_v_counter == V_LAST) begin
          v_n     = '0;
          frame_n = 1'b1;
        end else begin
          v_n = o_v_counter + CNT_W'(1);
        end
      end else begin
        h_n = o_h_counter + CNT_W'(1);
      end
    end

    act_n = (h_n >= H_OFS_C) && (v_n >= V_OFS_C);
    x_n   = act_n ? h_n - H_OFS_C : '0;
    y_n   = act_n ? v_n - V_OFS_C : '0;

    raw_n.hsync = ((h_n >= H_SYN_LO) && (h_n < H_SYN_HI)) ? HS_POL : ~HS_POL;
    raw_n.vsync = ((v_n >= V_SYN_LO) && (v_n < V_SYN_HI)) ? VS_POL : ~VS_POL;
    raw_n.de    = act_n;
    raw_n.blank = ~act_n;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_h_counter   <= '0;
      o_v_counter   <= '0;
      o_x           <= '0;
      o_y           <= '0;
      o_active      <= 1'b0;
      o_line_tick   <= 1'b0;
      o_frame_tick  <= 1'b0;
      o_frame_count <= '0;
      raw_q         <= RAW_IDLE;
    end else begin
      o_h_counter   <= h_n;
      o_v_counter   <= v_n;
      o_x           <= x_n;
      o_y           <= y_n;
      o_active      <= act_n;
      o_line_tick   <= line_n;
      o_frame_tick  <= frame_n;
      o_frame_count <= o_frame_count + FCNT_W'(frame_n);
      raw_q         <= raw_n;
    end
  end

  assign raw_bits = raw_q;

  sync_delay_line #(
    .WIDTH     (4),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (RAW_IDLE)
  ) u_sync_delay (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (raw_bits),
    .o_q   (del_bits)
  );

  assign {o_hsync, o_vsync, o_de, o_blank} = del_bits;

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  localparam int CW = 8;
  localparam int FW = 16;
  localparam int HT = 14;
  localparam int VT = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, en = 1'b1, rs = 1'b0;
  logic en_d = 1'b1, rs_d = 1'b0;

  // small-timing DUT, no delay
  logic [CW-1:0] d0_h, d0_v, d0_x, d0_y;
  logic          d0_act, d0_lt, d0_ft, d0_hs, d0_vs, d0_de, d0_bl;
  logic [FW-1:0] d0_fc;
  // small-timing DUT, delay 3
  logic [CW-1:0] d3_h, d3_v, d3_x, d3_y;
  logic          d3_act, d3_lt, d3_ft, d3_hs, d3_vs, d3_de, d3_bl;
  logic [FW-1:0] d3_fc;
  // default-timing DUT
  logic [10:0]   dd_h, dd_v, dd_x, dd_y;
  logic          dd_act, dd_lt, dd_ft, dd_hs, dd_vs, dd_de, dd_bl;
  logic [15:0]   dd_fc;

  video_timing_gen #(
    .CNT_W(CW), .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DELAY(0), .FCNT_W(FW)
  ) dut0 (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_resync(rs),
    .o_h_counter(d0_h), .o_v_counter(d0_v), .o_x(d0_x), .o_y(d0_y),
    .o_active(d0_act), .o_line_tick(d0_lt), .o_frame_tick(d0_ft),
    .o_frame_count(d0_fc), .o_hsync(d0_hs), .o_vsync(d0_vs),
    .o_de(d0_de), .o_blank(d0_bl)
  );

  video_timing_gen #(
    .CNT_W(CW), .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DELAY(3), .FCNT_W(FW)
  ) dut3 (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_resync(rs),
    .o_h_counter(d3_h), .o_v_counter(d3_v), .o_x(d3_x), .o_y(d3_y),
    .o_active(d3_act), .o_line_tick(d3_lt), .o_frame_tick(d3_ft),
    .o_frame_count(d3_fc), .o_hsync(d3_hs), .o_vsync(d3_vs),
    .o_de(d3_de), .o_blank(d3_bl)
  );

  video_timing_gen #(
    .PIPE_DELAY(0)
  ) dutd (
    .i_clk(clk), .i_rst(rst), .i_enable(en_d), .i_resync(rs_d),
    .o_h_counter(dd_h), .o_v_counter(dd_v), .o_x(dd_x), .o_y(dd_y),
    .o_active(dd_act), .o_line_tick(dd_lt), .o_frame_tick(dd_ft),
    .o_frame_count(dd_fc), .o_hsync(dd_hs), .o_vsync(dd_vs),
    .o_de(dd_de), .o_blank(dd_bl)
  );

  logic [54:0] a0, a3, e0, e3;
  assign a0 = {d0_h, d0_v, d0_x, d0_y, d0_act, d0_lt, d0_ft, d0_fc,
               d0_hs, d0_vs, d0_de, d0_bl};
  assign a3 = {d3_h, d3_v, d3_x, d3_y, d3_act, d3_lt, d3_ft, d3_fc,
               d3_hs, d3_vs, d3_de, d3_bl};

  int unsigned n_vec = 0, n_err = 0;

  // Reference model: raster position as a linear pixel index within the frame.
  int   m_h, m_v, m_fc;
  bit   m_lt, m_ft;
  logic [3:0] hist [0:3];   // {hsync,vsync,de,blank}; hist[k] = k cycles ago

  function automatic logic [3:0] raw_of(input int h, input int v);
    bit act = (h >= 6) && (v >= 3);
    bit hs  = !(h >= 2 && h < 4);
    bit vs  = (v != 1);
    return {hs, vs, act, !act};
  endfunction

  function automatic logic [54:0] exp_vec();
    bit act = (m_h >= 6) && (m_v >= 3);
    logic [CW-1:0] x, y;
    x = act ? CW'(m_h - 6) : '0;
    y = act ? CW'(m_v - 3) : '0;
    return {CW'(m_h), CW'(m_v), x, y, act, m_lt, m_ft, FW'(m_fc), raw_of(m_h, m_v)};
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_fc = 0; m_lt = 0; m_ft = 0;
    for (int k = 0; k < 4; k++) hist[k] = 4'b1101;
  endtask

  task automatic model_clock();
    int pos;
    if (rs) begin
      m_h = 0; m_v = 0; m_lt = 1; m_ft = 1;
      m_fc = (m_fc + 1) & 16'hFFFF;
    end else if (en) begin
      pos = m_v * HT + m_h + 1;
      if (pos == HT * VT) pos = 0;
      m_h = pos % HT; m_v = pos / HT;
      m_lt = (m_h == 0); m_ft = (pos == 0);
      if (m_ft) m_fc = (m_fc + 1) & 16'hFFFF;
    end else begin
      m_lt = 0; m_ft = 0;
    end
    for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = raw_of(m_h, m_v);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; rs = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; rs = 1'b0;
    model_reset();
    #1;
    e0 = exp_vec(); e3 = {e0[54:4], hist[3]}; n_vec++;
    if ({a0, a3} !== {e0, e3}) begin
      n_err++;
      $display("FAIL reset_state dut0=%h want %h dut3=%h want %h", a0, e0, a3, e3);
    end
    n_vec++;
    if ({dd_h, dd_v, dd_fc, dd_hs, dd_vs, dd_de, dd_bl, dd_ft} !==
        {11'd0, 11'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_default h=%0d v=%0d fc=%0d hs=%b bl=%b want 0 0 0 1 1",
               dd_h, dd_v, dd_fc, dd_hs, dd_bl);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_frames();
    int nlt = 0, nft = 0;
    do_reset();
    for (int i = 0; i < 3 * HT * VT; i++) begin
      tick();
      e0 = exp_vec(); e3 = {e0[54:4], hist[3]}; n_vec++;
      if ({a0, a3} !== {e0, e3}) begin
        n_err++;
        $display("FAIL frames cyc %0d dut0=%h want %h dut3=%h want %h", i, a0, e0, a3, e3);
      end
      nlt += d0_lt; nft += d0_ft;
    end
    n_vec++;
    if (nlt != 21 || nft != 3 || d0_fc !== 16'd3) begin
      n_err++;
      $display("FAIL frame_counts lines=%0d frames=%0d fc=%0d want 21 3 3", nlt, nft, d0_fc);
    end
  endtask

  task automatic test_enable_hold();
    int waited = 0;
    do_reset();
    for (int i = 0; i < 2 * HT + 5; i++) begin
      tick();
      e0 = exp_vec(); e3 = {e0[54:4], hist[3]}; n_vec++;
      if ({a0, a3} !== {e0, e3}) begin
        n_err++;
        $display("FAIL enable_pre cyc %0d dut0=%h want %h dut3=%h want %h", i, a0, e0, a3, e3);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      e0 = exp_vec(); e3 = {e0[54:4], hist[3]}; n_vec++;
      if ({a0, a3} !== {e0, e3}) begin
        n_err++;
        $display("FAIL enable_hold cyc %0d dut0=%h want %h dut3=%h want %h", i, a0, e0, a3, e3);
      end
      n_vec++;
      if (d0_h !== 8'd5 || d0_v !== 8'd2 || d0_lt !== 1'b0 || d0_ft !== 1'b0) begin
        n_err++;
        $display("FAIL enable_pos h=%0d v=%0d lt=%b ft=%b want 5 2 0 0", d0_h, d0_v, d0_lt, d0_ft);
      end
    end
    en = 1'b1;
    do begin
      tick();
      waited++;
      e0 = exp_vec(); e3 = {e0[54:4], hist[3]}; n_vec++;
      if ({a0, a3} !== {e0, e3}) begin
        n_err++;
        $display("FAIL enable_post cyc %0d dut0=%h want %h dut3=%h want %h", waited, a0, e0, a3, e3);
      end
    end while (d0_ft !== 1'b1 && waited < 200);
    n_vec++;
    if (waited != HT * VT - (2 * HT + 5)) begin
      n_err++;
      $display("FAIL enable_frame_delay got %0d cycles want %0d", waited, HT * VT - (2 * HT + 5));
    end
  endtask

  task automatic test_resync();
    logic [FW-1:0] fc0;
    do_reset();
    for (int i = 0; i < 4 * HT + 9; i++) begin
      tick();
      e0 = exp_vec(); e3 = {e0[54:4], hist[3]}; n_vec++;
      if ({a0, a3} !== {e0, e3}) begin
        n_err++;
        $display("FAIL resync_pre cyc %0d dut0=%h want %h dut3=%h want %h", i, a0, e0, a3, e3);
      end
    end
    for (int pass = 0; pass < 2; pass++) begin
      fc0 = d0_fc;
      rs = 1'b1;
      tick();
      rs = 1'b0;
      e0 = exp_vec(); e3 = {e0[54:4], hist[3]}; n_vec++;
      if ({a0, a3} !== {e0, e3}) begin
        n_err++;
        $display("FAIL resync_%0d dut0=%h want %h dut3=%h want %h", pass, a0, e0, a3, e3);
      end
      n_vec++;
      if (d0_h !== 8'd0 || d0_v !== 8'd0 || d0_ft !== 1'b1 || d0_lt !== 1'b1 ||
          d0_fc !== fc0 + 16'd1) begin
        n_err++;
        $display("FAIL resync_tick_%0d h=%0d v=%0d ft=%b lt=%b fc=%0d want 0 0 1 1 %0d",
                 pass, d0_h, d0_v, d0_ft, d0_lt, d0_fc, fc0 + 16'd1);
      end
      // second pass lands on the natural wrap point (13,6)
      for (int i = 0; i < HT * VT - 1; i++) begin
        tick();
        e0 = exp_vec(); e3 = {e0[54:4], hist[3]}; n_vec++;
        if ({a0, a3} !== {e0, e3}) begin
          n_err++;
          $display("FAIL resync_run cyc %0d dut0=%h want %h dut3=%h want %h", i, a0, e0, a3, e3);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int nft = 0;
    do_reset();
    for (int i = 0; i < 3 * HT + 7; i++) begin
      tick();
      e0 = exp_vec(); e3 = {e0[54:4], hist[3]}; n_vec++;
      if ({a0, a3} !== {e0, e3}) begin
        n_err++;
        $display("FAIL arst_pre cyc %0d dut0=%h want %h dut3=%h want %h", i, a0, e0, a3, e3);
      end
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    e0 = exp_vec(); e3 = {e0[54:4], hist[3]}; n_vec++;
    if ({a0, a3} !== {e0, e3}) begin
      n_err++;
      $display("FAIL arst_immediate dut0=%h want %h dut3=%h want %h", a0, e0, a3, e3);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < HT * VT; i++) begin
      tick();
      e0 = exp_vec(); e3 = {e0[54:4], hist[3]}; n_vec++;
      if ({a0, a3} !== {e0, e3}) begin
        n_err++;
        $display("FAIL arst_post cyc %0d dut0=%h want %h dut3=%h want %h", i, a0, e0, a3, e3);
      end
      if (i < HT * VT - 1) nft += d0_ft;
    end
    n_vec++;
    if (nft != 0 || d0_ft !== 1'b1) begin
      n_err++;
      $display("FAIL arst_first_tick early=%0d last=%b want 0 1", nft, d0_ft);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      en = ($urandom_range(0, 9) != 0);
      rs = ($urandom_range(0, 39) == 0);
      tick();
      e0 = exp_vec(); e3 = {e0[54:4], hist[3]}; n_vec++;
      if ({a0, a3} !== {e0, e3}) begin
        n_err++;
        $display("FAIL random cyc %0d en=%b rs=%b dut0=%h want %h dut3=%h want %h",
                 i, en, rs, a0, e0, a3, e3);
      end
    end
    en = 1'b1; rs = 1'b0;
  endtask

  task automatic test_default_timing();
    int h, v;
    logic [25:0] got, want;
    do_reset();
    for (int n = 1; n <= 2700; n++) begin
      @(posedge clk);
      #1;
      h = n % 1312; v = n / 1312;
      got  = {dd_h, dd_v, dd_hs, dd_de, dd_lt, dd_ft};
      want = {11'(h), 11'(v), !(h >= 16 && h < 112), 1'b0, (h == 0), 1'b0};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL default_timing n=%0d got %h want %h", n, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_enable_hold();
    test_resync();
    test_async_reset();
    test_random();
    test_default_timing();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised raster timing generator that replaces the hand-coded h/v counters, sync decode and frame-tick logic in the ULX3S top levels. It produces the raw counters consumed by pdp1_vga_crt, frame and line strobes, visible-area coordinates, a frame counter, and sync/DE/blank outputs. The sync/DE/blank outputs are delayed by a configurable number of cycles to match downstream pixel-pipeline latency before vga2dvid. Runtime pause and resynchronise controls are included, so animation/CPU blocks can be frame-locked.

Parameters:
CNT_W, 11, width of h/v counters and coordinates
H_VISIBLE, 1024, active pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, horizontal sync width
H_BP, 176, horizontal back porch
V_VISIBLE, 768, active lines
V_FP, 3, vertical front porch
V_SYNC, 6, vertical sync width
V_BP, 13, vertical back porch
HS_POL, 0, hsync active level
VS_POL, 0, vsync active level
PIPE_DELAY, 2, cycles of delay on hsync/vsync/de/blank (0 allowed)
FCNT_W, 16, frame counter width

Ports:
i_clk  in  1  pixel clock
i_rst  in  1  asynchronous active-high reset
i_enable  in  1  1 = counters advance; 0 = hold
i_resync  in  1  synchronous restart at (0,0)
o_h_counter  out  CNT_W  raw horizontal count
o_v_counter  out  CNT_W  raw vertical count
o_x  out  CNT_W  visible column (h - H_OFS), 0 outside active area
o_y  out  CNT_W  visible row (v - V_OFS), 0 outside active area
o_active  out  1  raw in-visible-area flag, aligned with counters
o_line_tick  out  1  1-cycle pulse when h wraps to 0
o_frame_tick  out  1  1-cycle pulse when (h,v) wraps to (0,0)
o_frame_count  out  FCNT_W  frames since reset
o_hsync  out  1  delayed hsync
o_vsync  out  1  delayed vsync
o_de  out  1  delayed data enable
o_blank  out  1  delayed ~de

Behaviour:
- Derived constants: H_TOTAL=H_FP+H_SYNC+H_BP+H_VISIBLE; H_OFS=H_FP+H_SYNC+H_BP; V terms likewise.
- Line order within each line and frame: front porch, sync, back porch, then visible area at the end. hsync is active for h in [H_FP, H_FP+H_SYNC). vsync uses the same rule on v.
- active = (h>=H_OFS)&&(v>=V_OFS).
- Reset (async assert on i_rst):
  - counters, o_x, o_y and o_frame_count = 0;
  - o_active, o_de, o_line_tick, o_frame_tick = 0; o_blank = 1;
  - o_hsync = ~HS_POL, o_vsync = ~VS_POL;
  - every delay-stage register is loaded with these inactive values.
- Deassertion is used as-is; the reset synchroniser lives in the top level.
- Counter step, per cycle with i_enable=1:
  - h increments;
  - at h==H_TOTAL-1, h goes to 0 and v increments;
  - at (H_TOTAL-1, V_TOTAL-1), both counters go to 0.
- All raw outputs (counters, x/y, active, ticks) are registers decoded from next-state, so they are consistent with o_h_counter in the same cycle.
- o_line_tick = 1 in the cycle where h==0 after a wrap. o_frame_tick = 1 in the cycle where (h,v)==(0,0) after a wrap; o_frame_count increments in that same cycle, mod 2^FCNT_W.
- The first (0,0) after reset produces no ticks.
- i_enable=0: counters, x/y and active hold; ticks are 0; frame_count holds.
- i_resync=1: counters go to (0,0) next cycle, with o_frame_tick=1, o_line_tick=1 and frame_count+1. It takes priority over i_enable=0. If it coincides with a natural wrap, only one tick and one increment result.
- Delay line:
  - shifts every cycle regardless of i_enable;
  - o_hsync/o_vsync/o_de/o_blank equal the raw decode from PIPE_DELAY cycles earlier;
  - PIPE_DELAY=0 means the outputs are aligned with the counters.
- Elaboration checks: every width parameter must be >0, and H_TOTAL and V_TOTAL must be < 2^CNT_W; otherwise elaboration fails.

Decomposition:
- Default 1024x768 timing constants and the derived offset/total formulas go in the shared definitions include, so top levels and pdp1_vga_crt use one source.
- One sub-module, sync_delay_line: parametrised WIDTH×DEPTH shift register with async active-high reset to a RESET_VAL vector. DEPTH=0 is pass-through.

Test Plan:
- Small timing (H 8/2/2/2 → H_TOTAL 14; V 4/1/1/1 → V_TOTAL 7), PIPE_DELAY=0, run 3 frames:
  - o_line_tick every 14 cycles; o_frame_tick every 98 cycles; frame_count 0→3;
  - hsync low exactly at h=2..3; o_de high only for h 6..13 with v 3..6; o_x 0..7, o_y 0..3.
- Same timing with PIPE_DELAY=3: o_hsync/o_de equal the PIPE_DELAY=0 waveform shifted exactly 3 cycles; raw ticks unchanged.
- i_enable low for 20 cycles at h=5, v=2: counters stay (5,2), no ticks. After release, the next frame_tick occurs 20 cycles later than the free-running reference.
- i_resync pulse at (9,4): next cycle counters are (0,0) with frame_tick=1 and frame_count+1. Pulsing at (13,6) yields a single tick and a single increment.
- i_rst asserted mid-frame at (7,3):
  - in the same cycle, before the next clock edge, all outputs go to reset values (hsync/vsync inactive per HS_POL/VS_POL, blank=1), including the delayed outputs;
  - after release, the counters start at (0,0) with no frame_tick until the first wrap.
- Default parameters: one frame is 1312×790 = 1,036,480 cycles between frame_ticks; hsync low for h 16..111 with HS_POL=0.
